// File: rtl/hrm_mem_arbiter.sv
// hrm_mem_arbiter: shares the single-port HRM tile RAM between the CPU datapath and the host loader port
module hrm_mem_arbiter #(
    parameter int AW = 5,
    parameter int DW = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] G_CPU = 2'd1;
    localparam logic [1:0] G_HOST = 2'd2;
    localparam logic [3:0] WMAX = 4'(MAX_WAIT);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] wait_cnt;
    logic       cpu_eff;
    logic       host_eff;

    // a port's request is masked in its own grant cycle since it was just consumed; host wins when starved
    always_comb begin
        cpu_eff = cpu_req & ~host_lock & (state != G_CPU);
        host_eff = host_req & (state != G_HOST);
        state_nxt = (host_eff && (wait_cnt == WMAX || !cpu_eff)) ? G_HOST : cpu_eff ? G_CPU : IDLE;
    end

    // grant state, host starvation counter and the captured access presented to the RAM
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            wait_cnt <= '0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_nxt;
            wait_cnt <= (state_nxt == G_HOST || !host_req) ? 4'd0 : (wait_cnt == WMAX) ? wait_cnt : wait_cnt + 4'd1;
            if (state_nxt == G_HOST) begin
                mem_we <= host_we;
                mem_addr <= host_addr;
                mem_wdata <= host_wdata;
            end else if (state_nxt == G_CPU) begin
                mem_we <= cpu_we;
                mem_addr <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end
        end
    end

    // read data comes back from the RAM one cycle after a read grant
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            cpu_rvalid <= 1'b0;
            host_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= (state == G_CPU) & ~mem_we;
            host_rvalid <= (state == G_HOST) & ~mem_we;
        end
    end

    assign mem_en = state != IDLE;
    assign cpu_gnt = state == G_CPU;
    assign host_gnt = state == G_HOST;
    assign cpu_rdata = mem_rdata;
    assign host_rdata = mem_rdata;
endmodule

// File: tb/tb_hrm_mem_arbiter.sv
// tb_hrm_mem_arbiter: two arbiters (MAX_WAIT 4 and 1) on shared random stimulus, each with its own RAM and reference model
module tb_hrm_mem_arbiter;
    logic       clk = 1'b0;
    logic       i_rst;
    logic       cpu_req, cpu_we, host_req, host_we, host_lock;
    logic [4:0] cpu_addr, host_addr;
    logic [7:0] cpu_wdata, host_wdata;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(int a);
        return (a == 3) ? 8'h2A : 8'(a * 37 + 5);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int MW = (g == 0) ? 4 : 1;
        logic        cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, mem_en, mem_we;
        logic [4:0]  mem_addr;
        logic [7:0]  cpu_rdata, host_rdata, mem_wdata, mem_rdata;
        logic [7:0]  ram [32];
        bit          loaded;
        bit          m_gc, m_gh, m_we, m_rvc, m_rvh, cpu_ok, host_ok, hw, cw, m_loaded;
        int          m_wait;
        logic [4:0]  m_addr;
        logic [7:0]  m_wd, m_rd;
        logic [7:0]  m_ram [32];
        logic [34:0] act, want;

        hrm_mem_arbiter #(.AW(5), .DW(8), .MAX_WAIT(MW)) dut (
            .clk(clk), .i_rst(i_rst),
            .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
            .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
            .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
            .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
            .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
        );

        // synchronous single-port RAM, preloaded once during the first reset
        always @(posedge clk) begin
            if (i_rst && !loaded) begin
                for (int i = 0; i < 32; i++) ram[i] <= init_val(i);
                loaded <= 1'b1;
            end else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
            else if (mem_en) mem_rdata <= ram[mem_addr];
        end

        // reference: who owns the RAM this cycle, how long the host has been refused, and memory contents
        always @(posedge clk or posedge i_rst) begin
            if (i_rst) begin
                if (!m_loaded) for (int i = 0; i < 32; i++) m_ram[i] = init_val(i);
                m_loaded = 1'b1;
                m_gc = 0; m_gh = 0; m_we = 0; m_rvc = 0; m_rvh = 0;
                m_wait = 0; m_addr = '0; m_wd = '0;
            end else begin
                cpu_ok = cpu_req && !host_lock && !m_gc;
                host_ok = host_req && !m_gh;
                hw = host_ok && (m_wait >= MW || !cpu_ok);
                cw = cpu_ok && !hw;
                m_rvc = m_gc && !m_we;
                m_rvh = m_gh && !m_we;
                if ((m_gc || m_gh) && !m_we) m_rd = m_ram[m_addr];
                if ((m_gc || m_gh) && m_we) m_ram[m_addr] = m_wd;
                m_wait = (hw || !host_req) ? 0 : (m_wait < MW ? m_wait + 1 : MW);
                if (hw) begin
                    m_we = host_we; m_addr = host_addr; m_wd = host_wdata;
                end else if (cw) begin
                    m_we = cpu_we; m_addr = cpu_addr; m_wd = cpu_wdata;
                end
                m_gc = cw;
                m_gh = hw;
            end
        end

        assign act = {cpu_gnt, host_gnt, mem_en, mem_we, mem_addr, mem_wdata, cpu_rvalid, host_rvalid, cpu_rdata, host_rdata};
        assign want = {m_gc, m_gh, m_gc | m_gh, m_we, m_addr, m_wd, m_rvc, m_rvh, m_rd, m_rd};
    end

    task automatic chk(input string name, input logic [7:0] a, input logic [7:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, a, e, $time);
        end
    endtask

    task automatic cmp(input int k, input logic [34:0] a, input logic [34:0] e);
        chk($sformatf("u%0d_cpu_gnt", k), 8'(a[34]), 8'(e[34]));
        chk($sformatf("u%0d_host_gnt", k), 8'(a[33]), 8'(e[33]));
        chk($sformatf("u%0d_mem_en", k), 8'(a[32]), 8'(e[32]));
        chk($sformatf("u%0d_mem_we", k), 8'(a[31]), 8'(e[31]));
        chk($sformatf("u%0d_mem_addr", k), 8'(a[30:26]), 8'(e[30:26]));
        chk($sformatf("u%0d_mem_wdata", k), a[25:18], e[25:18]);
        chk($sformatf("u%0d_cpu_rvalid", k), 8'(a[17]), 8'(e[17]));
        chk($sformatf("u%0d_host_rvalid", k), 8'(a[16]), 8'(e[16]));
        if (e[17]) chk($sformatf("u%0d_cpu_rdata", k), a[15:8], e[15:8]);
        if (e[16]) chk($sformatf("u%0d_host_rdata", k), a[7:0], e[7:0]);
    endtask

    task automatic tick();
        @(negedge clk);
        cmp(0, u[0].act, u[0].want);
        cmp(1, u[1].act, u[1].want);
    endtask

    task automatic idle(input int n);
        cpu_req = 0; host_req = 0; host_lock = 0;
        repeat (n) tick();
    endtask

    initial begin
        int cg, hg, found, b2b, prev;
        i_rst = 1; host_lock = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        repeat (3) tick();
        chk("rst_mem_en", 8'(u[0].mem_en), 8'd0);
        chk("rst_cpu_gnt", 8'(u[0].cpu_gnt), 8'd0);
        chk("rst_host_rvalid", 8'(u[0].host_rvalid), 8'd0);
        i_rst = 0;
        idle(2);

        cpu_req = 1; cpu_we = 0; cpu_addr = 5'd3;
        tick();
        chk("t1_cpu_gnt", 8'(u[0].cpu_gnt), 8'd1);
        chk("t1_mem_addr", 8'(u[0].mem_addr), 8'd3);
        chk("t1_host_gnt", 8'(u[0].host_gnt), 8'd0);
        cpu_req = 0;
        tick();
        chk("t1_cpu_rvalid", 8'(u[0].cpu_rvalid), 8'd1);
        chk("t1_cpu_rdata", u[0].cpu_rdata, 8'h2A);
        chk("t1_host_rvalid", 8'(u[0].host_rvalid), 8'd0);
        idle(1);

        host_req = 1; host_we = 1; host_addr = 5'd7; host_wdata = 8'h55;
        tick();
        chk("t2_wr_gnt", 8'(u[0].host_gnt), 8'd1);
        chk("t2_wr_we", 8'(u[0].mem_we), 8'd1);
        host_we = 0;
        tick();
        chk("t2_gap_gnt", 8'(u[0].host_gnt), 8'd0);
        tick();
        chk("t2_rd_gnt", 8'(u[0].host_gnt), 8'd1);
        chk("t2_rd_we", 8'(u[0].mem_we), 8'd0);
        host_req = 0;
        tick();
        chk("t2_rvalid", 8'(u[0].host_rvalid), 8'd1);
        chk("t2_rdata", u[0].host_rdata, 8'h55);
        idle(2);

        cpu_req = 1; cpu_addr = 5'd1; host_req = 1; host_addr = 5'd2;
        tick();
        chk("t3_first_cpu", 8'(u[0].cpu_gnt), 8'd1);
        tick();
        chk("t3_then_host", 8'(u[0].host_gnt), 8'd1);
        tick();
        chk("t3_then_cpu", 8'(u[0].cpu_gnt), 8'd1);
        idle(3);

        host_req = 1; host_addr = 5'd4;
        tick();
        chk("t4_host_gnt", 8'(u[1].host_gnt), 8'd1);
        tick();
        cpu_req = 1;
        tick();
        chk("t4_mw4_cpu", 8'(u[0].cpu_gnt), 8'd1);
        chk("t4_mw1_host", 8'(u[1].host_gnt), 8'd1);
        idle(3);

        host_lock = 1; cpu_req = 1; cpu_addr = 5'd5; host_req = 1; host_addr = 5'd6;
        cg = 0; hg = 0;
        repeat (20) begin
            tick();
            cg += int'(u[0].cpu_gnt);
            hg += int'(u[0].host_gnt);
        end
        chk("t5_lock_cpu_gnts", 8'(cg), 8'd0);
        chk("t5_lock_host_gnts", 8'(hg), 8'd10);
        host_lock = 0;
        found = 0;
        for (int i = 0; i < 2 && found == 0; i++) begin
            tick();
            if (u[0].cpu_gnt) found = 1;
        end
        chk("t5_release_cpu_gnt", 8'(found), 8'd1);
        idle(3);

        cpu_req = 1; cpu_addr = 5'd9;
        cg = 0; b2b = 0; prev = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 5) cpu_req = 0;
            if (u[0].cpu_gnt && prev != 0) b2b = 1;
            prev = int'(u[0].cpu_gnt);
            cg += prev;
        end
        chk("t6_grants", 8'(cg), 8'd3);
        chk("t6_back_to_back", 8'(b2b), 8'd0);
        idle(2);

        cpu_req = 1; cpu_addr = 5'd3;
        tick();
        chk("t7_gnt", 8'(u[0].cpu_gnt), 8'd1);
        cpu_req = 0; i_rst = 1;
        #1;
        chk("t7_rst_gnt", 8'(u[0].cpu_gnt), 8'd0);
        chk("t7_rst_mem_en", 8'(u[0].mem_en), 8'd0);
        chk("t7_rst_mem_addr", 8'(u[0].mem_addr), 8'd0);
        tick();
        i_rst = 0;
        tick();
        chk("t7_no_rvalid", 8'(u[0].cpu_rvalid), 8'd0);
        idle(2);

        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!cpu_req || u[0].cpu_gnt) begin
                cpu_req = $urandom_range(0, 3) != 0;
                cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 5'($urandom_range(0, 31));
                cpu_wdata = 8'($urandom_range(0, 255));
            end
            if (!host_req || u[0].host_gnt) begin
                host_req = $urandom_range(0, 1) != 0;
                host_we = 1'($urandom_range(0, 1));
                host_addr = 5'($urandom_range(0, 31));
                host_wdata = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 39) == 0) host_lock = !host_lock;
            i_rst = $urandom_range(0, 299) == 0;
        end
        i_rst = 0;
        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hrm_mem_arbiter.md
# hrm_mem_arbiter

Two-port arbiter that shares the single-port synchronous data RAM (the HRM "floor tiles") between the CPU datapath and the host debug/loader port. Arbitration decisions are registered, so each granted access occupies exactly one RAM cycle. Read data returns one cycle after the grant. CPU requests win by default. A starvation counter and a host lock guarantee that the host can inspect or load memory while a program is running.

## Interface
- AW, 5, RAM address width (32 tiles)
- DW, 8, data width
- MAX_WAIT, 4, consecutive cycles the host may be refused before it is forced to win; legal range 1..15

- clk  in  1  clock; all logic on posedge
- i_rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  CPU access request, level
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  one-cycle pulse: CPU request consumed
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  DW  read data to CPU
- host_req, host_we, host_addr, host_wdata  in  1/1/AW/DW  host request, same meaning as the CPU fields
- host_lock  in  1  while high, CPU requests are never granted
- host_gnt, host_rvalid  out  1  as for CPU
- host_rdata  out  DW  read data to host
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_en with mem_we=0

## Operation
- States:
  - IDLE: no access.
  - G_CPU: the CPU access is on the RAM this cycle.
  - G_HOST: the host access is on the RAM this cycle.
- Arbitration happens at every posedge and picks the next state from the effective requests.
- Masking:
  - cpu_eff = cpu_req & ~host_lock & (state != G_CPU).
  - host_eff = host_req & (state != G_HOST).
  - A port's request is masked in its own grant cycle, because that request has just been consumed.
- Decision:
  - If host_eff and (wait_cnt == MAX_WAIT or ~cpu_eff): go to G_HOST.
  - Else if cpu_eff: go to G_CPU.
  - Else: go to IDLE.
- On entering G_x, the arbiter captures that port's we/addr/wdata into mem_we/mem_addr/mem_wdata.
  - In G_x: mem_en=1 and x_gnt=1.
  - In IDLE: mem_en=0 and x_gnt=0.
- Requester rule:
  - Hold req/we/addr/wdata stable until gnt is seen high.
  - Drop req, or present a new request, on the next edge.
  - A req held high through the gnt cycle is treated as a new request.
- wait_cnt (4 bits):
  - Cleared when entering G_HOST or when host_req=0.
  - Otherwise incremented, saturating at MAX_WAIT, on every edge where host_req=1 and the next state is not G_HOST.
- Read return:
  - x_rvalid is registered. It is 1 in the cycle after G_x when the captured we was 0; otherwise 0.
  - cpu_rdata and host_rdata both pass mem_rdata through. Only rvalid qualifies them.
- Writes produce no rvalid.
- Result: alternating G_CPU/G_HOST is possible every cycle. A single port gets at most one access per 2 cycles.
- host_lock is intended for program load while the CPU is held or halted. A CPU request pending when lock rises is kept waiting, not dropped.

## Timing
- Reset values: state=IDLE, wait_cnt=0; mem_en, mem_we, cpu_gnt, host_gnt, cpu_rvalid, host_rvalid all 0; mem_addr=0, mem_wdata=0.
- Latency:
  - req high in cycle N → gnt and mem_en in cycle N+1 if it wins.
  - Read → rvalid and data in cycle N+2.
- Worst-case host latency with CPU saturating: MAX_WAIT+1 cycles from req to gnt.
- Simultaneous first requests with wait_cnt<MAX_WAIT: the CPU wins.
- Reset mid-operation:
  - All outputs go to their reset values immediately, asynchronously.
  - A pending rvalid is lost; the requester must reissue.
  - A write in its G cycle may or may not have reached the RAM.
- gnt and rvalid are never high for both ports in the same cycle.
- mem_en is never high for two accesses with the same captured request.

## Test plan
- Reset, then CPU read of addr 3 holding 0x2A → cpu_gnt at N+1, cpu_rvalid=1 with cpu_rdata=0x2A at N+2. Host outputs stay 0.
- Host write 0x55 to addr 7, then host read of addr 7 → host_gnt pulses twice, non-adjacent. Read returns 0x55. mem_we=1 only in the first grant.
- cpu_req and host_req both high continuously, MAX_WAIT=4 → the pattern starts with CPU. Host is granted no later than 5 cycles after request, then the CPU is granted the next cycle.
- host_lock=1 with cpu_req held → no cpu_gnt for 20 cycles while the host gets every other cycle. Lock drops → cpu_gnt within 2 cycles.
- i_rst pulsed in the G_CPU cycle of a read → cpu_rvalid stays 0. state=IDLE, and all outputs are 0 during reset.
- Single requester holding req high for 6 cycles → gnt pulses in alternate cycles (3 grants), never back-to-back.
